// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: pending-write scoreboard, two-requester
// round-robin grant, one-cycle registered register-file write port.
module reg_wb_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [3:0]        iss_dest,
  output logic              iss_ready,
  input  logic              a_valid,
  input  logic [3:0]        a_dest,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [3:0]        b_dest,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_write_enable,
  output logic [3:0]        rf_dest,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [3:0]        src_one,
  input  logic [3:0]        src_two,
  output logic              hazard_one,
  output logic              hazard_two,
  output logic              spurious_wr
);

  localparam logic LG_A = 1'b0;
  localparam logic LG_B = 1'b1;

  logic [15:0]       sb;
  logic [15:0]       sb_set;
  logic [15:0]       sb_clr;
  logic [15:0]       sb_next;
  logic              last_grant;
  logic              grant_a;
  logic              grant_b;
  logic              grant;
  logic [3:0]        g_dest;
  logic [DATA_W-1:0] g_data;
  logic              g_spurious;

  // On a conflict the requester that did not win last time gets the port.
  always_comb begin
    grant_a = a_valid & (~b_valid | (last_grant == LG_B));
    grant_b = b_valid & (~a_valid | (last_grant == LG_A));
    grant   = grant_a | grant_b;
    g_dest  = grant_a ? a_dest : b_dest;
    g_data  = grant_a ? a_data : b_data;
  end

  assign a_ready    = grant_a;
  assign b_ready    = grant_b;
  assign iss_ready  = ~sb[iss_dest];
  assign hazard_one = sb[src_one];
  assign hazard_two = sb[src_two];
  assign g_spurious = grant & (g_dest != 4'd0) & ~sb[g_dest];

  // Bits clear on the commit edge, not at grant, so a register stays
  // unclaimable until its value is actually in the register file.
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (iss_valid && iss_ready) sb_set[iss_dest] = 1'b1;
    if (rf_write_enable)        sb_clr[rf_dest]  = 1'b1;
    sb_next = ((sb & ~sb_clr) | sb_set) & 16'hFFFE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb          <= '0;
      last_grant  <= LG_B;
      spurious_wr <= 1'b0;
    end else begin
      sb <= sb_next;
      if (grant)      last_grant  <= grant_b ? LG_B : LG_A;
      if (g_spurious) spurious_wr <= 1'b1;
    end
  end

  // ---- stage p1: registered register-file write port ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_dest         <= '0;
      rf_data_in      <= '0;
    end else begin
      rf_write_enable <= grant & (g_dest != 4'd0);
      if (grant) begin
        rf_dest    <= g_dest;
        rf_data_in <= g_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomized scoreboard bench for reg_wb_arbiter against a behavioural model
// of pending registers, requesters and the write port.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid;
  logic [3:0]  iss_dest;
  logic        iss_ready;
  logic        a_valid;
  logic [3:0]  a_dest;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [3:0]  b_dest;
  logic [31:0] b_data;
  logic        b_ready;
  logic        rf_write_enable;
  logic [3:0]  rf_dest;
  logic [31:0] rf_data_in;
  logic [3:0]  src_one;
  logic [3:0]  src_two;
  logic        hazard_one;
  logic        hazard_two;
  logic        spurious_wr;

  reg_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_dest(iss_dest), .iss_ready(iss_ready),
    .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready),
    .rf_write_enable(rf_write_enable), .rf_dest(rf_dest), .rf_data_in(rf_data_in),
    .src_one(src_one), .src_two(src_two),
    .hazard_one(hazard_one), .hazard_two(hazard_two),
    .spurious_wr(spurious_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        we;
    bit [3:0]  dest;
    bit [31:0] data;
    bit        spur;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit [15:0] pend;
  int        last_winner;   // 0 = A granted most recently, 1 = B
  bit        m_we;
  bit [3:0]  m_dest;
  bit [31:0] m_data;
  bit        m_spur;

  // Requester state
  bit        av, bv, iv;
  bit [3:0]  ad, bd, idest, s1, s2;
  bit [31:0] adata, bdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit [3:0] pick_dest();
    int r;
    int cand[$];
    r = $urandom_range(0, 7);
    if (r == 0) return 4'd0;
    if (r < 6) begin
      for (int i = 1; i < 16; i++) if (pend[i]) cand.push_back(i);
      if (cand.size() != 0) return 4'(cand[$urandom_range(0, cand.size() - 1)]);
    end
    return 4'($urandom_range(1, 15));
  endfunction

  // Monitor: registered outputs are compared after every clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rf_write_enable", rf_write_enable, e.we);
        chk("rf_dest", rf_dest, e.dest);
        chk("rf_data_in", rf_data_in, e.data);
        chk("spurious_wr", spurious_wr, e.spur);
      end
    end
  end

  // Driver and reference model
  initial begin
    bit        do_rst, e_iss, ga, gb;
    bit [3:0]  gd;
    bit [31:0] gdata;
    bit [15:0] npend;
    exp_t      e;

    reset = 1'b1; iss_valid = 1'b0; iss_dest = '0;
    a_valid = 1'b0; a_dest = '0; a_data = '0;
    b_valid = 1'b0; b_dest = '0; b_data = '0;
    src_one = '0; src_two = '0;
    pend = '0; last_winner = 1; m_we = 0; m_dest = '0; m_data = '0; m_spur = 0;
    av = 0; bv = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      do_rst = (cyc < 2) || ($urandom_range(0, 149) == 0);
      if (!av && $urandom_range(0, 9) < 6) begin av = 1; ad = pick_dest(); adata = $urandom; end
      if (!bv && $urandom_range(0, 9) < 6) begin bv = 1; bd = pick_dest(); bdata = $urandom; end
      iv    = ($urandom_range(0, 1) == 1);
      idest = ($urandom_range(0, 3) == 0) ? pick_dest() : 4'($urandom_range(0, 15));
      s1    = ($urandom_range(0, 1) == 1) ? idest : 4'($urandom_range(0, 15));
      s2    = ($urandom_range(0, 1) == 1) ? m_dest : 4'($urandom_range(0, 15));

      reset = do_rst;
      iss_valid = iv; iss_dest = idest;
      a_valid = av; a_dest = ad; a_data = adata;
      b_valid = bv; b_dest = bd; b_data = bdata;
      src_one = s1; src_two = s2;
      #1;

      e_iss = !pend[idest];
      if (av && bv) begin
        ga = (last_winner == 1);
        gb = !ga;
      end else begin
        ga = av;
        gb = bv;
      end
      chk("iss_ready", iss_ready, e_iss);
      chk("a_ready", a_ready, ga);
      chk("b_ready", b_ready, gb);
      chk("hazard_one", hazard_one, pend[s1]);
      chk("hazard_two", hazard_two, pend[s2]);

      gd    = ga ? ad : bd;
      gdata = ga ? adata : bdata;
      if (do_rst) begin
        pend = '0; last_winner = 1;
        m_we = 0; m_dest = '0; m_data = '0; m_spur = 0;
      end else begin
        npend = pend;
        if (m_we) npend[m_dest] = 1'b0;
        if (iv && e_iss && idest != 0) npend[idest] = 1'b1;
        if (ga || gb) begin
          if (gd != 0 && !pend[gd]) m_spur = 1;
          m_we = (gd != 0);
          m_dest = gd;
          m_data = gdata;
          last_winner = ga ? 0 : 1;
        end else begin
          m_we = 0;
        end
        pend = npend;
      end
      e.we = m_we; e.dest = m_dest; e.data = m_data; e.spur = m_spur;
      exp_q.push_back(e);

      if (ga) av = 0;
      if (gb) bv = 0;
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; no other clock or reset SHALL exist.
REQ-002 The ports SHALL be as follows:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- iss_valid  in  1  issue stage claims a destination register.
- iss_dest  in  4  register being claimed.
- iss_ready  out  1  claim accepted this cycle (combinational).
- a_valid  in  1  ALU writeback request.
- a_dest  in  4  ALU destination.
- a_data  in  32  ALU result.
- a_ready  out  1  ALU request granted this cycle (combinational).
- b_valid  in  1  load-unit writeback request.
- b_dest  in  4  load destination.
- b_data  in  32  load data.
- b_ready  out  1  load request granted this cycle (combinational).
- rf_write_enable  out  1  register-file write strobe (registered).
- rf_dest  out  4  register-file write address (registered).
- rf_data_in  out  32  register-file write data (registered).
- src_one  in  4  read source 1 under query.
- src_two  in  4  read source 2 under query.
- hazard_one  out  1  src_one has a pending write (combinational).
- hazard_two  out  1  src_two has a pending write (combinational).
- spurious_wr  out  1  sticky error flag.

Function
REQ-003 The block SHALL hold a 16-bit scoreboard with one pending bit per register; bit 0 SHALL be constant 0.
REQ-004 iss_ready SHALL be high when the scoreboard bit for iss_dest is clear, regardless of iss_valid.
REQ-005 On a clock edge with iss_valid, iss_ready high and iss_dest non-zero, the block SHALL set the scoreboard bit for iss_dest.
REQ-006 With exactly one of a_valid or b_valid high, that requester SHALL be granted (ready high) in the same cycle.
REQ-007 With both valid, the grant SHALL go to the requester not granted most recently, using a 1-bit last_grant register.
REQ-008 last_grant SHALL update only on a grant.
REQ-009 No requester SHALL be granted when neither is valid, and at most one ready SHALL be high in any cycle.
REQ-010 On the edge after a grant, rf_dest and rf_data_in SHALL take the granted dest and data, and rf_write_enable SHALL be 1 if that dest is non-zero and 0 otherwise (latency 1 cycle).
REQ-011 In any cycle without a grant, rf_write_enable SHALL be 0; rf_dest and rf_data_in SHALL hold their previous values.
REQ-012 A scoreboard bit SHALL clear on the edge at which rf_write_enable is high for that register (write commit), not at grant.
REQ-013 A register being committed SHALL not be re-claimed in the same cycle, because iss_ready is still low.
REQ-014 A claim of one register and a commit of a different register in the same edge SHALL both take effect.
REQ-015 hazard_one and hazard_two SHALL equal the current scoreboard bit of src_one and src_two respectively.
REQ-016 A granted dest that is non-zero and whose scoreboard bit is clear SHALL set spurious_wr, which SHALL stay at 1 until reset.
REQ-017 A spurious write SHALL still be performed.
REQ-018 A requester SHALL hold valid, dest and data stable until ready; the block SHALL not check this.

Reset
REQ-019 On a reset edge, the scoreboard SHALL clear to 0 and last_grant SHALL become B, so that A wins the first conflict.
REQ-020 On a reset edge, rf_write_enable SHALL go to 0, rf_dest to 0, rf_data_in to 0x00000000, and spurious_wr to 0.
REQ-021 Reset SHALL take priority over all claims and grants in the same cycle, and any in-flight writeback SHALL be discarded.

Verification
REQ-022 Claim r5, then a_valid with dest 5 and data 0xDEADBEEF -> a_ready=1 that cycle; rf_write_enable=1, rf_dest=5, rf_data_in=0xDEADBEEF next cycle; hazard for src 5 is 1 until that edge and 0 after it.
REQ-023 Claim r3 and r7, then a_valid and b_valid held together for 4 cycles after reset -> grants A, B, A, B; rf_dest sequence follows the grants; no cycle has both ready high.
REQ-024 With r9 pending, iss_valid with dest 9 -> iss_ready=0 and the scoreboard is unchanged; it is accepted on the cycle after r9 commits.
REQ-025 b_valid with dest 0 and data 0x12345678 -> b_ready=1, rf_write_enable=0 next cycle, spurious_wr stays 0, scoreboard bit 0 stays 0.
REQ-026 a_valid with dest 4 and r4 not pending -> write is performed and spurious_wr=1 from the next cycle, held until reset.
REQ-027 Assert reset in the cycle after a grant of r6 -> rf_write_enable=0 and the scoreboard is all-zero after the edge; hazard_one=0 for src_one=6.
